// File: rtl/ddr2_req_arbiter.sv
// Round-robin arbiter sharing one DDR2 controller user port among NREQ requesters,
// one transaction in flight, with a watchdog that aborts transactions that never finish.
module ddr2_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int AW      = 26,
  parameter int DW      = 64,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ack,
  output logic [NREQ-1:0]    req_done,
  output logic [NREQ-1:0]    req_err,
  output logic [DW-1:0]      req_rdata,
  output logic               busy,
  output logic [AW-1:0]      c_addr,
  output logic [DW-1:0]      c_data_in,
  output logic               c_rd_req,
  output logic               c_wr_req,
  input  logic               c_rdy,
  input  logic [DW-1:0]      c_data_out
);

  // Handshakes: a requester holds req_rd/req_wr (level) until it sees req_ack, and
  // gets exactly one req_done (with req_err on abort) later. Controller side: the
  // request line and c_addr/c_data_in are held until c_rdy is sampled low (accepted);
  // completion is c_rdy sampled high again.

  localparam int GW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_DONE} state_t;

  state_t          state, state_d;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   gnt;
  logic            gnt_rd;
  logic [GW-1:0]   grant_idx;
  logic            grant_found;
  logic [GW:0]     cand;
  logic [WW-1:0]   wdog;
  logic            wdog_expired;
  logic [NREQ-1:0] pending;
  logic            do_grant, do_accept, do_complete, do_abort;

  assign pending      = req_rd | req_wr;
  assign wdog_expired = (wdog == WW'(TIMEOUT - 1));

  // First pending requester after last_grant, wrapping at NREQ-1.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant} + (GW+1)'(k);
      if (cand >= (GW+1)'(NREQ)) cand = cand - (GW+1)'(NREQ);
      if (!grant_found && pending[cand[GW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[GW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state;
    do_grant    = 1'b0;
    do_accept   = 1'b0;
    do_complete = 1'b0;
    do_abort    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (c_rdy && grant_found) begin
          do_grant = 1'b1;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (wdog_expired) begin
          do_abort = 1'b1;
          state_d  = ST_IDLE;
        end else if (!c_rdy) begin
          do_accept = 1'b1;
          state_d   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A real completion wins over a watchdog expiry in the same cycle.
        if (c_rdy) begin
          do_complete = 1'b1;
          state_d     = ST_IDLE;
        end else if (wdog_expired) begin
          do_abort = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack    <= '0;
      req_done   <= '0;
      req_err    <= '0;
      req_rdata  <= '0;
      busy       <= 1'b0;
      c_addr     <= '0;
      c_data_in  <= '0;
      c_rd_req   <= 1'b0;
      c_wr_req   <= 1'b0;
      last_grant <= GW'(NREQ - 1);
      gnt        <= '0;
      gnt_rd     <= 1'b0;
      wdog       <= '0;
    end else begin
      req_ack  <= '0;
      req_done <= '0;
      req_err  <= '0;
      busy     <= (state_d != ST_IDLE);
      if (state == ST_IDLE || state_d == ST_IDLE) wdog <= '0;
      else                                         wdog <= wdog + WW'(1);
      if (do_grant) begin
        gnt       <= grant_idx;
        gnt_rd    <= req_rd[grant_idx];
        req_ack   <= NREQ'(1) << grant_idx;
        c_addr    <= req_addr[grant_idx*AW +: AW];
        c_data_in <= req_wdata[grant_idx*DW +: DW];
        c_rd_req  <= req_rd[grant_idx];
        c_wr_req  <= ~req_rd[grant_idx];
      end
      if (do_accept || do_abort) begin
        c_rd_req <= 1'b0;
        c_wr_req <= 1'b0;
      end
      if (do_complete) begin
        if (gnt_rd) req_rdata <= c_data_out;
        req_done   <= NREQ'(1) << gnt;
        last_grant <= gnt;
      end
      if (do_abort) begin
        req_done   <= NREQ'(1) << gnt;
        req_err    <= NREQ'(1) << gnt;
        last_grant <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_ddr2_req_arbiter.sv
// Bench for ddr2_req_arbiter: directed scenarios plus randomized rounds, checked
// against a round-robin/memory reference model with a behavioural controller.
module tb_ddr2_req_arbiter;
  localparam int NREQ    = 4;
  localparam int AW      = 26;
  localparam int DW      = 64;
  localparam int TIMEOUT = 16;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req_rd, req_wr;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_ack, req_done, req_err;
  logic [DW-1:0]      req_rdata;
  logic               busy;
  logic [AW-1:0]      c_addr;
  logic [DW-1:0]      c_data_in;
  logic               c_rd_req, c_wr_req;
  logic               c_rdy;
  logic [DW-1:0]      c_data_out;

  ddr2_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack),
    .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata), .busy(busy),
    .c_addr(c_addr), .c_data_in(c_data_in), .c_rd_req(c_rd_req),
    .c_wr_req(c_wr_req), .c_rdy(c_rdy), .c_data_out(c_data_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] default_data(input logic [AW-1:0] a);
    return {a, 6'h2a, ~a, 6'h15};
  endfunction

  // ---------------- controller model ----------------
  int            ctl_acc = 2;
  int            ctl_done = 3;
  bit            ctl_hang = 1'b0;
  int            ctl_rise_cyc = 0;
  bit            ctl_cap_rd, ctl_cap_wr, ctl_first, ctl_deassert_ok;
  logic [AW-1:0] ctl_cap_addr;
  logic [DW-1:0] ctl_cap_data;
  logic [DW-1:0] ctl_mem [logic [AW-1:0]];

  initial begin
    int st;
    int cnt;
    st = 0;
    cnt = 0;
    c_rdy = 1'b1;
    c_data_out = '0;
    forever begin
      tick();
      if (!rst_n) begin
        st = 0;
        c_rdy = 1'b1;
      end else begin
        case (st)
          0: if (c_rd_req || c_wr_req) begin
               cnt = ctl_acc;
               st = 1;
             end
          1: begin
               cnt--;
               if (cnt <= 0) begin
                 ctl_cap_rd = c_rd_req;
                 ctl_cap_wr = c_wr_req;
                 ctl_cap_addr = c_addr;
                 ctl_cap_data = c_data_in;
                 c_rdy = 1'b0;
                 cnt = ctl_done;
                 ctl_first = 1'b1;
                 st = 2;
               end
             end
          default: begin
               if (ctl_first) begin
                 ctl_deassert_ok = !c_rd_req && !c_wr_req;
                 ctl_first = 1'b0;
               end
               if (!ctl_hang) begin
                 cnt--;
                 if (cnt <= 0) begin
                   if (ctl_cap_rd)
                     c_data_out = ctl_mem.exists(ctl_cap_addr) ? ctl_mem[ctl_cap_addr]
                                                               : default_data(ctl_cap_addr);
                   else if (ctl_cap_wr)
                     ctl_mem[ctl_cap_addr] = ctl_cap_data;
                   c_rdy = 1'b1;
                   ctl_rise_cyc = cyc;
                   st = 0;
                 end
               end
             end
        endcase
      end
    end
  end

  // ---------------- reference model ----------------
  int            ref_lg = NREQ - 1;
  logic [DW-1:0] ref_rdata = '0;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] exp_q[$];

  function automatic int exp_grant();
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ref_lg + k) % NREQ;
      if (req_rd[idx] || req_wr[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_rd[i] = rd;
    req_wr[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  // Runs one full transaction for the requester the model predicts, checking
  // the grant, the controller-side request, the completion and read data.
  task automatic serve_one(input bit chk_lat, output int g_out);
    int            g, n, stray, start_cyc, ack_cyc, done_cyc;
    bit            rd;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    g_out = -1;
    start_cyc = cyc;
    g = exp_grant();
    if (g < 0) begin
      check("model_pending", 0, 1);
      return;
    end
    rd = req_rd[g];
    a = req_addr[g*AW +: AW];
    d = req_wdata[g*DW +: DW];
    n = 0;
    stray = 0;
    while (req_ack == '0 && n < 60) begin
      tick();
      n++;
      if (req_done != '0) stray++;
    end
    ack_cyc = cyc;
    check("ack_onehot", req_ack, 64'(1) << g);
    if (req_ack == '0) return;
    if (chk_lat) check("grant_latency", ack_cyc, start_cyc + 1);
    check("stray_done_before_ack", stray, 0);
    check("c_rd_req_at_ack", c_rd_req, rd);
    check("c_wr_req_at_ack", c_wr_req, !rd);
    check("c_addr_at_ack", c_addr, a);
    if (!rd) check("c_data_in_at_ack", c_data_in, d);
    check("busy_at_ack", busy, 1);
    if (rd) req_rd[g] = 1'b0;
    else    req_wr[g] = 1'b0;
    n = 0;
    stray = 0;
    while (req_done == '0 && n < 40) begin
      tick();
      n++;
      if (req_ack != '0) stray++;
    end
    done_cyc = cyc;
    check("done_onehot", req_done, 64'(1) << g);
    check("err_clear", req_err, 0);
    check("stray_ack_in_flight", stray, 0);
    check("done_latency", done_cyc, ctl_rise_cyc + 1);
    check("busy_at_done", busy, 0);
    check("ctl_req_low_at_done", {c_rd_req, c_wr_req}, 0);
    check("ctl_saw_op_held", {ctl_cap_rd, ctl_cap_wr}, {rd, !rd});
    check("ctl_saw_addr_held", ctl_cap_addr, a);
    if (!rd) check("ctl_saw_wdata_held", ctl_cap_data, d);
    check("ctl_req_dropped_after_accept", ctl_deassert_ok, 1);
    if (rd) exp_q.push_back(ref_mem.exists(a) ? ref_mem[a] : default_data(a));
    else begin
      ref_mem[a] = d;
      exp_q.push_back(ref_rdata);
    end
    ref_rdata = exp_q.pop_front();
    check("rdata", req_rdata, ref_rdata);
    ref_lg = g;
    g_out = g;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int            g, prev, n, stray, a_cyc, mask, op;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    req_rd = '0;
    req_wr = '0;
    req_addr = '0;
    req_wdata = '0;
    ctl_mem[26'h2adbeef] = 64'hDEAD_BEEF_0123_4567;
    ref_mem[26'h2adbeef] = 64'hDEAD_BEEF_0123_4567;

    // reset state
    repeat (3) tick();
    check("rst_ack", req_ack, 0);
    check("rst_done", req_done, 0);
    check("rst_err", req_err, 0);
    check("rst_busy", busy, 0);
    check("rst_c_req", {c_rd_req, c_wr_req}, 0);
    check("rst_c_addr", c_addr, 0);
    check("rst_rdata", req_rdata, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // single read from requester 0
    ctl_acc = 2;
    ctl_done = 10;
    set_req(0, 1'b1, 1'b0, 26'h2adbeef, '0);
    serve_one(1'b1, g);
    check("t1_grant", g, 0);
    check("t1_rdata_const", req_rdata, 64'hDEAD_BEEF_0123_4567);

    // single write from requester 2
    ctl_acc = 3;
    ctl_done = 4;
    set_req(2, 1'b0, 1'b1, 26'h0000040, 64'h1122334455667788);
    serve_one(1'b1, g);
    check("t2_grant", g, 2);
    check("t2_rdata_kept", req_rdata, 64'hDEAD_BEEF_0123_4567);

    // round robin with all four pending, re-requesting for the first four grants
    for (int i = 0; i < NREQ; i++)
      set_req(i, 1'($urandom_range(0, 1)), 1'b1, AW'(i * 8), {$urandom, $urandom});
    prev = ref_lg;
    for (int i = 0; i < 8; i++) begin
      ctl_acc = $urandom_range(1, 3);
      ctl_done = $urandom_range(1, 6);
      serve_one(1'b1, g);
      check("rr_order", g, (prev + 1) % NREQ);
      check("rr_not_repeated", g == prev, 0);
      if (i < 4 && g >= 0) begin
        req_rd[g] = 1'b0;
        req_wr[g] = 1'b1;
        req_wdata[g*DW +: DW] = {$urandom, $urandom};
      end
      prev = g;
    end
    check("rr_drained", {req_rd, req_wr}, 0);

    // requester 1 with read and write both set, requester 2 reading
    set_req(1, 1'b1, 1'b1, 26'h0000018, 64'h0badcafe_55aa55aa);
    set_req(2, 1'b1, 1'b0, 26'h0000040, '0);
    serve_one(1'b1, g);
    check("rdwr_first_is_req1", g, 1);
    serve_one(1'b1, g);
    check("rdwr_second_is_req2", g, 2);
    serve_one(1'b1, g);
    check("rdwr_third_is_req1", g, 1);

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      mask = $urandom_range(1, (1 << NREQ) - 1);
      for (int i = 0; i < NREQ; i++) begin
        if (mask[i]) begin
          op = $urandom_range(0, 2);
          a = AW'($urandom_range(0, 7) * 8);
          set_req(i, op != 1, op != 0, a, {$urandom, $urandom});
        end
      end
      n = 0;
      while ((req_rd | req_wr) != '0 && n < 16) begin
        ctl_acc = $urandom_range(1, 3);
        ctl_done = $urandom_range(1, 6);
        serve_one(1'b1, g);
        n++;
        if (g < 0) break;
      end
      check("rand_round_drained", {req_rd, req_wr}, 0);
    end

    // watchdog: controller accepts and never completes
    ctl_hang = 1'b1;
    ctl_acc = 1;
    ctl_done = 2;
    set_req(1, 1'b1, 1'b0, 26'h0000123, '0);
    n = 0;
    while (req_ack == '0 && n < 20) begin tick(); n++; end
    a_cyc = cyc;
    check("wd_ack", req_ack, 4'b0010);
    req_rd[1] = 1'b0;
    n = 0;
    while (req_done == '0 && n < 40) begin tick(); n++; end
    check("wd_done", req_done, 4'b0010);
    check("wd_err", req_err, 4'b0010);
    check("wd_timeout_cycles", cyc - a_cyc, TIMEOUT);
    check("wd_busy_fell", busy, 0);
    check("wd_c_req_low", {c_rd_req, c_wr_req}, 0);
    check("wd_rdata_kept", req_rdata, ref_rdata);
    ref_lg = 1;
    set_req(3, 1'b0, 1'b1, 26'h0000200, 64'hfeedface_01020304);
    stray = 0;
    repeat (6) begin
      tick();
      if (req_ack != '0) stray++;
    end
    check("wd_no_grant_while_not_rdy", stray, 0);
    check("wd_idle_busy", busy, 0);
    ctl_hang = 1'b0;
    serve_one(1'b0, g);
    check("wd_next_grant", g, 3);

    // asynchronous reset during WAIT_DONE
    ctl_acc = 1;
    ctl_done = 12;
    set_req(2, 1'b1, 1'b0, 26'h0000077, '0);
    n = 0;
    while (req_ack == '0 && n < 20) begin tick(); n++; end
    check("rst_t_ack", req_ack, 4'b0100);
    req_rd[2] = 1'b0;
    repeat (4) tick();
    check("rst_t_busy_before", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_c_req", {c_rd_req, c_wr_req}, 0);
    check("async_rst_c_addr", c_addr, 0);
    check("async_rst_pulses", {req_ack, req_done, req_err}, 0);
    check("async_rst_rdata", req_rdata, 0);
    ref_lg = NREQ - 1;
    ref_rdata = '0;
    set_req(2, 1'b0, 1'b1, 26'h0000050, 64'h0123456789abcdef);
    set_req(0, 1'b1, 1'b0, 26'h2adbeef, '0);
    repeat (3) tick();
    rst_n = 1'b1;
    ctl_acc = 2;
    ctl_done = 3;
    serve_one(1'b1, g);
    check("post_rst_first_grant", g, 0);
    serve_one(1'b1, g);
    check("post_rst_second_grant", g, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
